// File: rtl/hba_cmd_master.sv
// HBA bus initiator: one valid/ready command -> one request/grant/select bus transfer -> one response; HBA_CMD_MASTER_TIMEOUT_EN adds the ack timeout abort.
// Latency: accept to rsp_valid = grant wait + ack wait + 3 cycles; cmd_ready is held low until the previous response has been consumed.
module hba_cmd_master #(
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rnw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DBUS_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DBUS_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  hba_mrequest,
  input  logic                  hba_mgrant,
  output logic                  hba_select,
  output logic                  hba_rnw,
  output logic [ADDR_WIDTH-1:0] hba_abus,
  output logic [DBUS_WIDTH-1:0] hba_dbus,
  input  logic [DBUS_WIDTH-1:0] hba_dbus_slave,
  input  logic                  hba_xferack_slave
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, RESP} state_t;

  state_t                state;
  logic                  lat_rnw;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DBUS_WIDTH-1:0] lat_wdata;
  logic                  timeout;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("hba_cmd_master: TIMEOUT_CYCLES must be in 1..65535");
  end

`ifdef HBA_CMD_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt;

  // Held at zero outside XFER, so it is already clear on the first XFER cycle.
  always_ff @(posedge hba_clk) begin
    if (hba_reset || state != XFER) to_cnt <= '0;
    else                             to_cnt <= to_cnt + 16'd1;
  end

  assign timeout = (to_cnt == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      state        <= IDLE;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      hba_mrequest <= 1'b0;
      hba_select   <= 1'b0;
      hba_rnw      <= 1'b0;
      hba_abus     <= '0;
      hba_dbus     <= '0;
      lat_rnw      <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            lat_rnw      <= cmd_rnw;
            lat_addr     <= cmd_addr;
            lat_wdata    <= cmd_wdata;
            cmd_ready    <= 1'b0;
            hba_mrequest <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (hba_mgrant) begin
            hba_select <= 1'b1;
            hba_rnw    <= lat_rnw;
            hba_abus   <= lat_addr;
            hba_dbus   <= lat_wdata;
            state      <= XFER;
          end
        end
        XFER: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (hba_xferack_slave || timeout) begin
            hba_select   <= 1'b0;
            hba_mrequest <= 1'b0;
            hba_rnw      <= 1'b0;
            hba_abus     <= '0;
            hba_dbus     <= '0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= (hba_xferack_slave && lat_rnw) ? hba_dbus_slave : '0;
            rsp_err      <= timeout && !hba_xferack_slave;
            state        <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hba_cmd_master.sv
// Bench for hba_cmd_master: directed scenarios plus randomized transfers, each checked against timing and data expectations
// derived from the bus rules (select length, err, rdata, latency, idle gaps), with or without HBA_CMD_MASTER_TIMEOUT_EN.
module tb_hba_cmd_master;

  localparam int DW = 8;
  localparam int AW = 12;
  localparam int TO = 4;

  logic          hba_clk = 1'b0;
  logic          hba_reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_rnw = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          hba_mrequest;
  logic          hba_mgrant = 1'b0;
  logic          hba_select;
  logic          hba_rnw;
  logic [AW-1:0] hba_abus;
  logic [DW-1:0] hba_dbus;
  logic [DW-1:0] hba_dbus_slave = '0;
  logic          hba_xferack_slave = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;
  bit prev_sel = 1'b0;
  bit seen_sel = 1'b0;
  int idle_run = 0;

  always #5 hba_clk = ~hba_clk;

  hba_cmd_master #(
    .DBUS_WIDTH(DW), .PERIPH_ADDR_WIDTH(4), .REG_ADDR_WIDTH(8),
    .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .hba_clk(hba_clk), .hba_reset(hba_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .hba_mrequest(hba_mrequest), .hba_mgrant(hba_mgrant), .hba_select(hba_select),
    .hba_rnw(hba_rnw), .hba_abus(hba_abus), .hba_dbus(hba_dbus),
    .hba_dbus_slave(hba_dbus_slave), .hba_xferack_slave(hba_xferack_slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hba_clk);
    #1;
  endtask

  // Reference rules: select lasts until the ack cycle, or TO cycles when the timeout exists and the ack is later.
  function automatic int exp_sel_cycles(input int ack_dly);
`ifdef HBA_CMD_MASTER_TIMEOUT_EN
    return (ack_dly < TO) ? ack_dly + 1 : TO;
`else
    return ack_dly + 1;
`endif
  endfunction

  function automatic bit exp_err(input int ack_dly);
`ifdef HBA_CMD_MASTER_TIMEOUT_EN
    return ack_dly >= TO;
`else
    return 1'b0;
`endif
  endfunction

  // Inactive masters must drive zeros, and transfers must be separated by at least two idle bus cycles.
  always @(negedge hba_clk) begin
    if (mon_en) begin
      if (hba_select !== 1'b1) begin
        chk("bus_zero_idle", 32'({hba_rnw, hba_abus, hba_dbus}), 32'd0);
        idle_run++;
      end else if (!prev_sel) begin
        if (seen_sel) chk("idle_gap_ge2", 32'(idle_run >= 2), 32'd1);
        seen_sel = 1'b1;
        idle_run = 0;
      end
      prev_sel = (hba_select === 1'b1);
    end
  end

  task automatic run_xfer(input bit rnw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [DW-1:0] sd, input int gnt_dly, input int ack_dly,
                          input int rrdy_dly, input string tag);
    int            sel_n;
    int            lat;
    bit            ok;
    bit            ee;
    logic [DW-1:0] er;
    ee = exp_err(ack_dly);
    er = (rnw && !ee) ? sd : '0;
    chk({tag, ".idle_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wd;
    tick();
    lat = 1;
    cmd_valid = 1'b0; cmd_rnw = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
    ok = 1'b1;
    for (int i = 0; i < gnt_dly; i++) begin
      if (!(hba_mrequest === 1'b1 && hba_select === 1'b0 && cmd_ready === 1'b0)) ok = 1'b0;
      tick();
      lat++;
    end
    if (!(hba_mrequest === 1'b1 && hba_select === 1'b0 && cmd_ready === 1'b0)) ok = 1'b0;
    chk({tag, ".req_phase"}, 32'(ok), 32'd1);
    hba_mgrant = 1'b1;
    tick();
    lat++;
    hba_mgrant = 1'b0;
    ok = 1'b1;
    sel_n = 0;
    while (hba_select === 1'b1 && sel_n < 300) begin
      if (!(hba_abus === addr && hba_dbus === wd && hba_rnw === rnw && hba_mrequest === 1'b1)) ok = 1'b0;
      hba_xferack_slave = (sel_n == ack_dly);
      hba_dbus_slave    = (sel_n == ack_dly) ? sd : DW'($urandom);
      tick();
      lat++;
      sel_n++;
    end
    hba_xferack_slave = 1'b0;
    hba_dbus_slave    = '0;
    chk({tag, ".bus_hold"}, 32'(ok), 32'd1);
    chk({tag, ".select_cycles"}, 32'(sel_n), 32'(exp_sel_cycles(ack_dly)));
    chk({tag, ".latency"}, 32'(lat), 32'(gnt_dly + exp_sel_cycles(ack_dly) + 2));
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rsp_rdata"}, 32'(rsp_rdata), 32'(er));
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(ee));
    chk({tag, ".bus_released"}, 32'({hba_mrequest, hba_select, hba_rnw, hba_abus, hba_dbus}), 32'd0);
    chk({tag, ".busy"}, 32'(cmd_ready), 32'd0);
    ok = 1'b1;
    for (int i = 0; i < rrdy_dly; i++) begin
      hba_xferack_slave = 1'($urandom);
      hba_dbus_slave    = DW'($urandom);
      tick();
      if (!(rsp_valid === 1'b1 && rsp_rdata === er && rsp_err === ee &&
            cmd_ready === 1'b0 && hba_select === 1'b0)) ok = 1'b0;
    end
    hba_xferack_slave = 1'b0;
    hba_dbus_slave    = '0;
    chk({tag, ".resp_hold"}, 32'(ok), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, ".rsp_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".ready_again"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] b_addr [3];
    logic [DW-1:0] b_wd [3];
    bit            b_rnw [3];
    int            acc;
    int            rsp;
    int            cyc;
    bit            ok;
    bit            accept_now;

    // Reset state
    hba_reset = 1'b1;
    tick(); tick();
    chk("reset.cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset.outputs", 32'({rsp_valid, rsp_rdata, rsp_err, hba_mrequest, hba_select, hba_rnw}), 32'd0);
    chk("reset.buses", 32'({hba_abus, hba_dbus}), 32'd0);
    hba_reset = 1'b0;
    tick();
    mon_en = 1'b1;

    run_xfer(1'b0, 12'h102, 8'h5A, 8'hFF, 1, 2, 0, "write");
    run_xfer(1'b1, 12'h201, 8'h00, 8'hC3, 1, 1, 5, "read");
`ifdef HBA_CMD_MASTER_TIMEOUT_EN
    run_xfer(1'b1, 12'h3A5, 8'h11, 8'h7E, 0, 1000, 1, "timeout");
    run_xfer(1'b1, 12'h3A6, 8'h22, 8'h81, 0, TO - 1, 1, "ack_at_timeout");
`else
    run_xfer(1'b1, 12'h3A5, 8'h11, 8'h7E, 0, 12, 1, "no_timeout");
`endif
    run_xfer(1'b0, 12'hF0F, 8'hA5, 8'h00, 20, 0, 0, "grant_stall");

    // Reset while select is high
    cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 12'h456; cmd_wdata = 8'h99;
    tick();
    cmd_valid = 1'b0;
    hba_mgrant = 1'b1;
    tick();
    hba_mgrant = 1'b0;
    chk("rst_mid.select_up", 32'(hba_select), 32'd1);
    tick();
    hba_reset = 1'b1;
    tick();
    hba_reset = 1'b0;
    chk("rst_mid.dropped", 32'({hba_select, hba_mrequest, rsp_valid}), 32'd0);
    chk("rst_mid.cmd_ready", 32'(cmd_ready), 32'd1);
    run_xfer(1'b1, 12'h457, 8'h00, 8'h3C, 2, 1, 1, "after_reset");

    // Back-to-back: three queued commands, auto grant/ack, response always consumed
    for (int i = 0; i < 3; i++) begin
      b_addr[i] = AW'($urandom);
      b_wd[i]   = DW'($urandom);
      b_rnw[i]  = (i != 1);
    end
    acc = 0; rsp = 0; cyc = 0; ok = 1'b1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_rnw = b_rnw[0]; cmd_addr = b_addr[0]; cmd_wdata = b_wd[0];
    while (rsp < 3 && cyc < 100) begin
      hba_mgrant        = hba_mrequest;
      hba_xferack_slave = hba_select;
      hba_dbus_slave    = hba_select ? (b_addr[rsp][7:0] ^ 8'hA5) : '0;
      if (hba_select === 1'b1 && hba_abus !== b_addr[rsp]) ok = 1'b0;
      accept_now = cmd_valid && (cmd_ready === 1'b1);
      if (accept_now && (rsp_valid !== 1'b0 || rsp != acc)) ok = 1'b0;
      if (rsp_valid === 1'b1) begin
        chk("b2b.rdata", 32'(rsp_rdata), 32'(b_rnw[rsp] ? (b_addr[rsp][7:0] ^ 8'hA5) : 8'h00));
        rsp++;
      end
      tick();
      cyc++;
      if (accept_now) begin
        acc++;
        if (acc < 3) begin
          cmd_rnw = b_rnw[acc]; cmd_addr = b_addr[acc]; cmd_wdata = b_wd[acc];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    rsp_ready = 1'b0; hba_mgrant = 1'b0; hba_xferack_slave = 1'b0; hba_dbus_slave = '0; cmd_valid = 1'b0;
    chk("b2b.accept_order", 32'(ok), 32'd1);
    chk("b2b.accepted", 32'(acc), 32'd3);
    chk("b2b.responses", 32'(rsp), 32'd3);
    tick();

    // Randomized transfers
    for (int t = 0; t < 24; t++) begin
      run_xfer(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
               $urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 3), "rand");
      if ($urandom_range(0, 1) == 1) tick();
    end

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
